// File: rtl/pu_msp430_timer16_pkg.sv
// Register offsets, CTL/FLG bit positions, mode encoding and prescaler divide
// decode shared by the MSP430 16-bit compare timer.
package pu_msp430_timer16_pkg;

    localparam int unsigned OFS_CTL  = 0;
    localparam int unsigned OFS_CNT  = 2;
    localparam int unsigned OFS_FLG  = 4;
    localparam int unsigned OFS_CCR0 = 6;

    typedef enum logic [1:0] {
        MODE_STOP = 2'd0,
        MODE_UP   = 2'd1,
        MODE_CONT = 2'd2
    } mode_e;

    localparam int unsigned CTL_MODE_LSB = 0;
    localparam int unsigned CTL_DIV_LSB  = 2;
    localparam int unsigned CTL_CLR_BIT  = 4;
    localparam int unsigned CTL_IE_LSB   = 8;
    localparam int unsigned CTL_OVIE_BIT = 15;
    localparam int unsigned FLG_OV_BIT   = 15;

    // Terminal prescaler value for DIV codes /1, /2, /4, /8.
    function automatic logic [2:0] div_last(input logic [1:0] div);
        logic [2:0] last;
        case (div)
            2'd0:    last = 3'd0;
            2'd1:    last = 3'd1;
            2'd2:    last = 3'd3;
            default: last = 3'd7;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/pu_msp430_timer16_presc.sv
// Three-bit timer prescaler; tick marks the mclk cycle in which the counter advances.
module pu_msp430_timer16_presc
    import pu_msp430_timer16_pkg::*;
(
    input  logic       mclk,
    input  logic       puc_rst,
    input  logic       run,
    input  logic [1:0] div,
    input  logic       clr,
    output logic       tick
);

    logic [2:0] presc_q;
    logic [2:0] presc_d;

    // ">=" lets a shrinking divider fire on the next cycle instead of wrapping through 7.
    assign tick = run & (presc_q >= div_last(div));

    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = 3'd0;
        end else if (run) begin
            presc_d = tick ? 3'd0 : presc_q + 3'd1;
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            presc_q <= 3'd0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/pu_msp430_timer16_ccr.sv
// MSP430 per_* bus timer: prescaled 16-bit up/continuous counter with NCH
// compare channels, write-1-to-clear flags and a level interrupt.
module pu_msp430_timer16_ccr
    import pu_msp430_timer16_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h01A0,
    parameter int          DEC_WD    = 4,
    parameter int          NCH       = 4
) (
    input  logic           mclk,
    input  logic           puc_rst,
    input  logic [13:0]    per_addr,
    input  logic [15:0]    per_din,
    input  logic           per_en,
    input  logic [1:0]     per_we,
    output logic [15:0]    per_dout,
    output logic           irq,
    output logic [NCH-1:0] cmp_out
);

    localparam int               IDX_W    = DEC_WD - 1;
    localparam logic [IDX_W-1:0] IDX_CTL  = IDX_W'(OFS_CTL / 2);
    localparam logic [IDX_W-1:0] IDX_CNT  = IDX_W'(OFS_CNT / 2);
    localparam logic [IDX_W-1:0] IDX_FLG  = IDX_W'(OFS_FLG / 2);
    localparam int               IDX_CCR0 = OFS_CCR0 / 2;
    localparam logic [15:0]      CH_MASK  = 16'((1 << NCH) - 1);
    localparam logic [15:0]      CTL_MASK = 16'h000F | (CH_MASK << CTL_IE_LSB) | (16'h1 << CTL_OVIE_BIT);
    localparam logic [15:0]      FLG_MASK = CH_MASK | (16'h1 << FLG_OV_BIT);

    logic             reg_sel, reg_wr, reg_rd;
    logic [IDX_W-1:0] word_idx;
    logic [15:0]      lane_mask;
    logic             ctl_wr, cnt_wr, flg_wr, clr;
    logic [NCH-1:0]   ccr_wr;
    logic [1:0]       mode;
    logic             run, tick, tick_en;
    logic [15:0]      ctl_q, ctl_d, cnt_q, cnt_d, flg_q, flg_d;
    logic [15:0]      cnt_nxt, flg_set, flg_clr, rd_data;
    logic [15:0]      ccr_q [NCH];
    logic [15:0]      ccr_d [NCH];
    logic [NCH-1:0]   match, cmp_q, cmp_d;

    function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                               input logic [15:0] new_v,
                                               input logic [15:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    always_comb begin
        reg_sel   = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
        reg_wr    = reg_sel & (per_we != 2'b00);
        reg_rd    = reg_sel & (per_we == 2'b00);
        word_idx  = per_addr[IDX_W-1:0];
        lane_mask = {{8{per_we[1]}}, {8{per_we[0]}}};
        ctl_wr    = reg_wr & (word_idx == IDX_CTL);
        cnt_wr    = reg_wr & (word_idx == IDX_CNT);
        flg_wr    = reg_wr & (word_idx == IDX_FLG);
        clr       = ctl_wr & per_we[0] & per_din[CTL_CLR_BIT];
        ccr_wr    = '0;
        for (int i = 0; i < NCH; i++) begin
            ccr_wr[i] = reg_wr & (word_idx == IDX_W'(IDX_CCR0 + i));
        end
    end

    pu_msp430_timer16_presc u_presc (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .run     (run),
        .div     (ctl_q[CTL_DIV_LSB +: 2]),
        .clr     (clr | cnt_wr),
        .tick    (tick)
    );

    // A bus write to CNT or a CLR pre-empts the count step, so no match fires that cycle.
    always_comb begin
        mode    = ctl_q[CTL_MODE_LSB +: 2];
        run     = (mode == MODE_UP) || (mode == MODE_CONT);
        tick_en = tick & ~clr & ~cnt_wr;
        cnt_nxt = cnt_q + 16'd1;
        if ((mode == MODE_UP) && (cnt_q == ccr_q[0])) begin
            cnt_nxt = 16'h0000;
        end
        for (int i = 0; i < NCH; i++) begin
            match[i] = tick_en & (cnt_nxt == ccr_q[i]);
        end
        flg_set             = 16'(match);
        flg_set[FLG_OV_BIT] = tick_en & (cnt_nxt == 16'h0000);
        cmp_d               = match;
    end

    always_comb begin
        ctl_d = ctl_wr ? (lane_merge(ctl_q, per_din, lane_mask) & CTL_MASK) : ctl_q;

        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 16'h0000;
        end else if (cnt_wr) begin
            cnt_d = lane_merge(cnt_q, per_din, lane_mask);
        end else if (tick_en) begin
            cnt_d = cnt_nxt;
        end

        // Set is applied after clear so a same-cycle event survives a write-1-to-clear.
        flg_clr = flg_wr ? (per_din & lane_mask) : 16'h0000;
        flg_d   = ((flg_q & ~flg_clr) | flg_set) & FLG_MASK;

        for (int i = 0; i < NCH; i++) begin
            ccr_d[i] = ccr_wr[i] ? lane_merge(ccr_q[i], per_din, lane_mask) : ccr_q[i];
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            ctl_q <= 16'h0000;
            cnt_q <= 16'h0000;
            flg_q <= 16'h0000;
            cmp_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                ccr_q[i] <= 16'h0000;
            end
        end else begin
            ctl_q <= ctl_d;
            cnt_q <= cnt_d;
            flg_q <= flg_d;
            cmp_q <= cmp_d;
            for (int i = 0; i < NCH; i++) begin
                ccr_q[i] <= ccr_d[i];
            end
        end
    end

    always_comb begin
        rd_data = 16'h0000;
        if (word_idx == IDX_CTL) rd_data = ctl_q;
        if (word_idx == IDX_CNT) rd_data = cnt_q;
        if (word_idx == IDX_FLG) rd_data = flg_q;
        for (int i = 0; i < NCH; i++) begin
            if (word_idx == IDX_W'(IDX_CCR0 + i)) rd_data = ccr_q[i];
        end
        per_dout = reg_rd ? rd_data : 16'h0000;
    end

    assign irq     = (|(flg_q[NCH-1:0] & ctl_q[CTL_IE_LSB +: NCH])) | (flg_q[FLG_OV_BIT] & ctl_q[CTL_OVIE_BIT]);
    assign cmp_out = cmp_q;

endmodule

// File: doc/pu_msp430_timer16_ccr.md
Name: pu_msp430_timer16_ccr

Overview:
- Parametrised 16-bit peripheral timer for the MSP430 peripheral bus.
- Register set: control, counter, flag, and NCH compare registers.
- Adds a prescaled free-running/up counter, compare-match flags, write-1-to-clear, byte-lane writes and an interrupt output.
- Sits on the per_* bus beside the other 16-bit peripherals; irq goes to the interrupt controller.

Parameters:
- BASE_ADDR, 15'h01A0, byte base address; aligned to 2^DEC_WD.
- DEC_WD, 4, address decode width in bytes.
- NCH, 4, number of compare channels; 1..8 and 6+2*NCH <= 2^DEC_WD.

Ports:
- mclk  in  1  main system clock
- puc_rst  in  1  main system reset
- per_addr  in  14  peripheral word address
- per_din  in  16  write data
- per_en  in  1  peripheral enable
- per_we  in  2  byte write enables ([0] low byte, [1] high byte)
- per_dout  out  16  read data; 0 when not selected
- irq  out  1  timer interrupt request
- cmp_out  out  NCH  per-channel match pulse, 1 cycle

Behaviour:
- Clock and reset: one clock, mclk. Reset puc_rst is asynchronous and active-high. Reset clears all registers, prescaler, irq and cmp_out to 0.
- Decode: reg_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]).
- Write: per_we != 0. Each lane updates only if its per_we bit is set.
- Read: per_we == 0. Combinational, no side effects.
- Register map (byte offsets):
  - 0x0 CTL
  - 0x2 CNT
  - 0x4 FLG
  - 0x6+2i CCRi, i = 0..NCH-1
  - Unmapped offsets read 0 and ignore writes.
- CTL bits:
  - [1:0] MODE: 0 stop, 1 up-to-CCR0, 2 continuous, 3 stop.
  - [3:2] DIV: prescale /1, /2, /4, /8.
  - [4] CLR: write-only, reads 0. Writing 1 sets CNT=0 and prescaler=0 on the next edge.
  - [8+i] IEi: per-channel interrupt enable.
  - [15] OVIE: overflow interrupt enable.
  - Other bits read 0.
- Prescaler: 3-bit counter, runs only when MODE is 1 or 2. tick = (presc == div-1); presc wraps to 0 on tick. A DIV change takes effect from the current presc value; if presc >= new div-1, the next cycle ticks.
- Counter on tick:
  - MODE 1: cnt_nxt = (cnt == CCR0) ? 0 : cnt+1.
  - MODE 2: cnt_nxt = cnt+1, wrapping 0xFFFF to 0.
  - MODE 0/3: counter and prescaler hold.
- Flags:
  - On a tick, FLG[i] is set if cnt_nxt == CCRi.
  - FLG[15] (overflow) is set when cnt_nxt == 0 due to wrap.
  - cmp_out[i] pulses for 1 cycle with the FLG[i] set.
  - FLG bits are set on the same edge CNT updates.
- FLG write: 1 clears the bit, per byte lane. A set event in the same cycle wins over a clear.
- CNT write: loads per_din by lanes and zeroes the prescaler. No tick and no match are evaluated that cycle. CLR wins over a simultaneous CNT write.
- Up mode edge cases:
  - CCR0 = 0: cnt stays 0; FLG0 and FLG15 set every tick.
  - CNT > CCR0: counts up to 0xFFFF, wraps to 0 and sets FLG15.
- irq = |(FLG[NCH-1:0] & IE) | (FLG[15] & OVIE). Combinational from registers, so it is visible the cycle after the set edge.
- Reset mid-count: immediate asynchronous clear. Counting restarts only after MODE is rewritten.

Decomposition:
- Package pu_msp430_timer16_pkg holds:
  - register offset constants
  - MODE enum (STOP, UP, CONT)
  - CTL bit-position constants
  - DIV decode function
- One sub-module, pu_msp430_timer16_presc: prescaler with run, div and clr inputs and a tick output.
- Decoder, registers and read mux stay in the top module.

Test Plan:
- Reset, then read all offsets -> every read returns 0x0000; irq=0.
- Write CCR0=3, CTL=0x8001 (up, /1, OVIE) -> CNT sequence 0,1,2,3,0. FLG=0x8001 after the wrap edge; irq rises the next cycle.
- Write CTL=0x000A (continuous, /4), CNT=0xFFFE -> CNT steps every 4 mclk. Reaching 0x0000 sets FLG[15], with 8 mclk from write to wrap.
- Byte write per_we=2'b10 to CCR1 with per_din=0xAB12 over CCR1=0x0034 -> CCR1 reads 0xAB34.
- Write FLG=0x0001 in the same cycle as a CCR0 match -> FLG[0] remains 1. A later clear with no match -> 0; irq drops.
- Assert puc_rst mid-count in MODE 2 -> CNT, FLG, CTL, irq and cmp_out go 0 immediately. CNT stays 0 after reset release until CTL is written.
